// File: rtl/datapath_arbiter_if.sv
// Requester and datapath handshake bundle for datapath_arbiter.
// slave is the arbiter's view; master is the requesters plus datapath.
interface datapath_arbiter_if #(
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int RESULT_WIDTH      = 12
);
  logic                         req0_valid;
  logic                         req1_valid;
  logic [INSTRUCTION_WIDTH-1:0] req0_instruction;
  logic [INSTRUCTION_WIDTH-1:0] req1_instruction;
  logic                         req0_lock;
  logic                         req1_lock;
  logic                         req0_ready;
  logic                         req1_ready;
  logic                         req0_done;
  logic                         req1_done;
  logic [RESULT_WIDTH-1:0]      req0_result;
  logic [RESULT_WIDTH-1:0]      req1_result;
  logic                         req0_error;
  logic                         req1_error;
  logic                         dp_start;
  logic [INSTRUCTION_WIDTH-1:0] dp_instruction;
  logic                         dp_finished;
  logic [RESULT_WIDTH-1:0]      dp_result;

  modport slave (
    input  req0_valid, req1_valid, req0_instruction, req1_instruction,
    input  req0_lock, req1_lock, dp_finished, dp_result,
    output req0_ready, req1_ready, req0_done, req1_done,
    output req0_result, req1_result, req0_error, req1_error,
    output dp_start, dp_instruction
  );

  modport master (
    output req0_valid, req1_valid, req0_instruction, req1_instruction,
    output req0_lock, req1_lock, dp_finished, dp_result,
    input  req0_ready, req1_ready, req0_done, req1_done,
    input  req0_result, req1_result, req0_error, req1_error,
    input  dp_start, dp_instruction
  );
endinterface

// File: rtl/datapath_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of a start/finished datapath,
// with optional grant locking and a completion watchdog.
module datapath_arbiter #(
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int RESULT_WIDTH      = 12,
  parameter int TIMEOUT           = 255
) (
  input  logic              i_clock,
  input  logic              i_resetn,
  datapath_arbiter_if.slave bus,
  output logic              o_busy,
  output logic              o_owner
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [7:0] WD_LAST  = 8'(TIMEOUT - 1);

  logic [1:0]                   r_state;
  logic                         r_owner;
  logic                         r_lock_held;
  logic [7:0]                   r_wd;
  logic                         r_dp_start;
  logic [INSTRUCTION_WIDTH-1:0] r_dp_instruction;

  logic [1:0]                   w_valid;
  logic [1:0]                   w_lock;
  logic [1:0]                   w_ready;
  logic [1:0]                   w_done;
  logic [1:0]                   w_error;
  logic [INSTRUCTION_WIDTH-1:0] w_instruction [2];
  logic [RESULT_WIDTH-1:0]      w_result [2];
  logic                         w_grant;
  logic                         w_idle_ready;
  logic                         w_accept;
  logic                         w_complete;
  logic                         w_timeout;

  assign w_valid          = {bus.req1_valid, bus.req0_valid};
  assign w_lock           = {bus.req1_lock, bus.req0_lock};
  assign w_instruction[0] = bus.req0_instruction;
  assign w_instruction[1] = bus.req1_instruction;

  // A held lock pins the grant even while the owner has nothing valid.
  always_comb begin
    w_grant = ~r_owner;
    if (r_lock_held) begin
      w_grant = r_owner;
    end else if (w_valid == 2'b01) begin
      w_grant = 1'b0;
    end else if (w_valid == 2'b10) begin
      w_grant = 1'b1;
    end
  end

  // dp_finished gating also blocks grants after a watchdog or reset while the datapath is still busy.
  assign w_idle_ready = (r_state == ST_IDLE) && bus.dp_finished && i_resetn;
  assign w_accept     = |(w_ready & w_valid);
  assign w_complete   = (r_state == ST_WAIT) && (bus.dp_finished || (r_wd == WD_LAST));
  assign w_timeout    = (r_state == ST_WAIT) && !bus.dp_finished && (r_wd == WD_LAST);

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
      logic                    r_done;
      logic                    r_error;
      logic [RESULT_WIDTH-1:0] r_result;

      assign w_ready[gi] = w_idle_ready && (w_grant == 1'(gi));

      always_ff @(posedge i_clock or negedge i_resetn) begin
        if (!i_resetn) begin
          r_done   <= 1'b0;
          r_error  <= 1'b0;
          r_result <= '0;
        end else begin
          r_done <= 1'b0;
          if (w_complete && (r_owner == 1'(gi))) begin
            r_done   <= 1'b1;
            r_error  <= w_timeout;
            r_result <= w_timeout ? '0 : bus.dp_result;
          end
        end
      end

      assign w_done[gi]   = r_done;
      assign w_error[gi]  = r_error;
      assign w_result[gi] = r_result;
    end
  endgenerate

  // lock_held only changes at accept, so an unlocked instruction releases the grant at its completion.
  always_ff @(posedge i_clock or negedge i_resetn) begin
    if (!i_resetn) begin
      r_state          <= ST_IDLE;
      r_owner          <= 1'b1;
      r_lock_held      <= 1'b0;
      r_wd             <= '0;
      r_dp_start       <= 1'b0;
      r_dp_instruction <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_dp_instruction <= w_instruction[w_grant];
            r_dp_start       <= 1'b1;
            r_owner          <= w_grant;
            r_lock_held      <= w_lock[w_grant];
            r_wd             <= '0;
            r_state          <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_dp_start <= 1'b0;
          r_state    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (w_complete) begin
            r_state <= ST_IDLE;
          end else begin
            r_wd <= r_wd + 8'd1;
          end
        end
        default: begin
          r_dp_start <= 1'b0;
          r_state    <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.req0_ready     = w_ready[0];
  assign bus.req1_ready     = w_ready[1];
  assign bus.req0_done      = w_done[0];
  assign bus.req1_done      = w_done[1];
  assign bus.req0_error     = w_error[0];
  assign bus.req1_error     = w_error[1];
  assign bus.req0_result    = w_result[0];
  assign bus.req1_result    = w_result[1];
  assign bus.dp_start       = r_dp_start;
  assign bus.dp_instruction = r_dp_instruction;
  assign o_busy             = (r_state != ST_IDLE);
  assign o_owner            = r_owner;

endmodule
